pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard and flow controller for the in-order RISC-V pipeline; the successor to the current fixed 5-stage core, which has no hazard handling.
- Tracks in-flight destination registers from EX through WB, detects RAW hazards for the instruction in ID, and issues stall, bubble and flush controls.
- With forwarding compiled in, it also issues registered operand-forward selects for the EX-stage operand muxes.
- Sits beside the control unit and drives the enables of the IF/ID and ID/EX pipeline registers.

---
 rtl/zp_pipe_pkg.sv | 34 +++
 rtl/pipe_scoreboard.sv | 59 +++++
 rtl/pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/zp_pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// sb_entry_t  : one in-flight scoreboard slot {v, rd, we, ld}.
// FWD_*       : EX operand-mux select encodings.
// SB_EX_IDX   : scoreboard index that corresponds to the EX stage.
// sb_match()  : RAW match of one slot against a source register.
package zp_pipe_pkg;

  // Widest register address the scoreboard can hold; narrower ports are zero-extended.
  localparam int unsigned RD_MAX_W = 8;

  typedef logic [RD_MAX_W-1:0] sb_rd_t;

  typedef struct packed {
    logic   v;
    sb_rd_t rd;
    logic   we;
    logic   ld;
  } sb_entry_t;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;
  localparam logic [1:0] FWD_RET = 2'd3;

  localparam int unsigned SB_EX_IDX = 0;

  localparam sb_entry_t SB_BUBBLE = '0;

  // x0 is hardwired to zero, so a write to it never creates a dependency.
  function automatic logic sb_match(sb_entry_t e, sb_rd_t rs, logic rs_used);
    return e.v & e.we & (e.rd != '0) & (e.rd == rs) & rs_used;
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// In-flight destination scoreboard: a shift register of sb_entry_t, index 0 = EX,
// index Entries-1 = WB.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   shift_i                 advance all entries one stage toward WB
//   insert_i, ins_entry_i   on shift, load ins_entry_i into entry 0 (else a bubble)
//   rs1_i/rs2_i, use1_i/use2_i  source registers of the ID instruction
//   valid_o                 per-entry valid bits
//   ex_load_o               entry 0 holds a load
//   match1_o, match2_o      per-entry RAW match against rs1 / rs2
module pipe_scoreboard
  import zp_pipe_pkg::*;
#(
  parameter int unsigned Entries = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               shift_i,
  input  logic               insert_i,
  input  sb_entry_t          ins_entry_i,
  input  sb_rd_t             rs1_i,
  input  sb_rd_t             rs2_i,
  input  logic               use1_i,
  input  logic               use2_i,
  output logic [Entries-1:0] valid_o,
  output logic               ex_load_o,
  output logic [Entries-1:0] match1_o,
  output logic [Entries-1:0] match2_o
);

  sb_entry_t [Entries-1:0] sb_q, sb_d;

  always_comb begin
    sb_d = sb_q;
    if (shift_i) begin
      for (int i = int'(Entries) - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0] = insert_i ? ins_entry_i : SB_BUBBLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  for (genvar g = 0; g < int'(Entries); g++) begin : g_match
    assign valid_o[g]  = sb_q[g].v;
    assign match1_o[g] = sb_match(sb_q[g], rs1_i, use1_i);
    assign match2_o[g] = sb_match(sb_q[g], rs2_i, use2_i);
  end

  assign ex_load_o = sb_q[SB_EX_IDX].ld;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and flow controller for the in-order pipeline. Tracks in-flight
// destinations EX..WB, stalls the ID instruction on RAW hazards, flushes on
// taken branches and counts stall cycles.
// Build option: define HAZARD_FWD_EN to build operand forwarding; hazards are
// then limited to load-use and fwd_a_o/fwd_b_o carry registered EX mux selects.
// Ports:
//   clk_i, reset_i                  clock, synchronous active-high reset
//   id_*_i                          decoded fields of the instruction in ID
//   ex_br_taken_i                   branch/jump resolved taken in EX
//   stall_if_o, stall_id_o          hold PC+IF/ID, hold ID
//   bubble_ex_o, flush_ifid_o       NOP into ID/EX, invalidate IF/ID
//   fwd_a_o, fwd_b_o                registered EX operand source selects
//   inflight_o                      number of valid tracked entries
//   stall_cnt_o                     saturating stall-cycle counter
module pipe_hazard_ctrl
  import zp_pipe_pkg::*;
#(
  parameter int unsigned STAGES = 5,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      id_valid_i,
  input  logic [RA_W-1:0]           id_rs1_i,
  input  logic [RA_W-1:0]           id_rs2_i,
  input  logic                      id_use1_i,
  input  logic                      id_use2_i,
  input  logic [RA_W-1:0]           id_rd_i,
  input  logic                      id_regwen_i,
  input  logic                      id_load_i,
  input  logic                      ex_br_taken_i,
  output logic                      stall_if_o,
  output logic                      stall_id_o,
  output logic                      bubble_ex_o,
  output logic                      flush_ifid_o,
  output logic [1:0]                fwd_a_o,
  output logic [1:0]                fwd_b_o,
  output logic [$clog2(STAGES)-1:0] inflight_o,
  output logic [CNT_W-1:0]          stall_cnt_o
);

  localparam int unsigned Entries = STAGES - 2;
  localparam int unsigned IcntW   = $clog2(STAGES);

  logic [Entries-1:0] valid, match1, match2;
  logic               ex_load;
  logic               hz_raw, hz, br, insert;
  sb_entry_t          ins_entry;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  assign ins_entry = '{v: 1'b1, rd: sb_rd_t'(id_rd_i), we: id_regwen_i, ld: id_load_i};

  // A taken branch kills the wrong-path ID instruction, so it never enters EX.
  assign insert = id_valid_i & ~hz_raw & ~ex_br_taken_i;

  pipe_scoreboard #(
    .Entries (Entries)
  ) u_scoreboard (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .shift_i     (1'b1),
    .insert_i    (insert),
    .ins_entry_i (ins_entry),
    .rs1_i       (sb_rd_t'(id_rs1_i)),
    .rs2_i       (sb_rd_t'(id_rs2_i)),
    .use1_i      (id_use1_i),
    .use2_i      (id_use2_i),
    .valid_o     (valid),
    .ex_load_o   (ex_load),
    .match1_o    (match1),
    .match2_o    (match2)
  );

`ifdef HAZARD_FWD_EN
  // Only a load in EX cannot be forwarded in time.
  assign hz_raw = id_valid_i & ex_load & (match1[SB_EX_IDX] | match2[SB_EX_IDX]);

  logic [1:0] sel_a, sel_b;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

  // Where the producer sitting in entry idx will be during the consumer's EX cycle.
  function automatic logic [1:0] idx_code(int idx, logic ld);
    if (idx == 0) begin
      return ld ? FWD_RF : FWD_MEM;
    end else if (idx == 1) begin
      return FWD_WB;
    end else if ((STAGES > 4) && (idx == int'(STAGES) - 3)) begin
      return FWD_RET;
    end
    return FWD_RF;
  endfunction

  // Scan oldest to youngest so the nearest producer overwrites the rest.
  always_comb begin
    sel_a = FWD_RF;
    sel_b = FWD_RF;
    for (int i = int'(Entries) - 1; i >= 0; i--) begin
      if (match1[i]) sel_a = idx_code(i, ex_load);
      if (match2[i]) sel_b = idx_code(i, ex_load);
    end
    fwd_a_d = insert ? sel_a : FWD_RF;
    fwd_b_d = insert ? sel_b : FWD_RF;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign fwd_a_o = fwd_a_q;
  assign fwd_b_o = fwd_b_q;
`else
  // The regfile write lands at the end of WB, so every tracked entry is a hazard.
  assign hz_raw = id_valid_i & ((|match1) | (|match2));

  logic unused_ex_load;
  assign unused_ex_load = ex_load;

  assign fwd_a_o = FWD_RF;
  assign fwd_b_o = FWD_RF;
`endif

  // Combinational controls are forced quiet while reset is held.
  assign hz = hz_raw & ~reset_i;
  assign br = ex_br_taken_i & ~reset_i;

  assign stall_if_o   = hz & ~br;
  assign stall_id_o   = hz & ~br;
  assign bubble_ex_o  = hz | br;
  assign flush_ifid_o = br;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_if_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  always_comb begin
    inflight_o = '0;
    for (int i = 0; i < int'(Entries); i++) begin
      inflight_o = inflight_o + IcntW'(valid[i]);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int STAGES = 5;
  localparam int N      = STAGES - 2;
`ifdef HAZARD_FWD_EN
  localparam bit Fwd = 1'b1;
`else
  localparam bit Fwd = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_use1, id_use2, id_regwen, id_load, ex_br_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall_if, stall_id, bubble_ex, flush_ifid;
  logic [1:0] fwd_a, fwd_b;
  logic [2:0] inflight;
  logic [15:0] stall_cnt;
  logic [2:0] inflight_s;
  logic [3:0] stall_cnt_s;
  logic       unused_si, unused_sd, unused_be, unused_fl;
  logic [1:0] unused_fa, unused_fb;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.STAGES(STAGES), .RA_W(5), .CNT_W(16)) dut (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_use1_i(id_use1), .id_use2_i(id_use2), .id_rd_i(id_rd),
    .id_regwen_i(id_regwen), .id_load_i(id_load), .ex_br_taken_i(ex_br_taken),
    .stall_if_o(stall_if), .stall_id_o(stall_id), .bubble_ex_o(bubble_ex),
    .flush_ifid_o(flush_ifid), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .inflight_o(inflight), .stall_cnt_o(stall_cnt)
  );

  // Narrow counter instance shares all stimulus; it exercises saturation quickly.
  pipe_hazard_ctrl #(.STAGES(STAGES), .RA_W(5), .CNT_W(4)) dut_s (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs1_i(id_rs1),
    .id_rs2_i(id_rs2), .id_use1_i(id_use1), .id_use2_i(id_use2), .id_rd_i(id_rd),
    .id_regwen_i(id_regwen), .id_load_i(id_load), .ex_br_taken_i(ex_br_taken),
    .stall_if_o(unused_si), .stall_id_o(unused_sd), .bubble_ex_o(unused_be),
    .flush_ifid_o(unused_fl), .fwd_a_o(unused_fa), .fwd_b_o(unused_fb),
    .inflight_o(inflight_s), .stall_cnt_o(stall_cnt_s)
  );

  typedef struct {
    bit v; int rs1; int rs2; bit u1; bit u2; int rd; bit we; bit ld;
  } id_t;

  // Reference model: log of instructions that left ID, stamped with the cycle they left.
  typedef struct { int t; int rd; bit we; bit ld; } ins_t;
  ins_t hist[$];
  int   cyc;
  int   m_cnt, m_cnt_s, m_fa, m_fb;
  int   tests, fails;
  bit   last_adv, obs_stall;

  function automatic id_t mk(bit v, int rs1, int rs2, bit u1, bit u2, int rd, bit we, bit ld);
    id_t r;
    r.v = v; r.rs1 = rs1; r.rs2 = rs2; r.u1 = u1; r.u2 = u2; r.rd = rd; r.we = we; r.ld = ld;
    return r;
  endfunction

  // Does a source read in the current cycle collide with an unfinished write?
  function automatic bit m_hz(int rs, bit used);
    if (!used || rs == 0) return 1'b0;
    foreach (hist[i]) begin
      int d;
      d = cyc - hist[i].t;
      if (hist[i].we && hist[i].rd == rs && d >= 1 && d <= N) begin
        if (!Fwd) return 1'b1;
        if (d == 1 && hist[i].ld) return 1'b1;
      end
    end
    return 1'b0;
  endfunction

  // Forward source chosen from the age of the youngest matching producer.
  function automatic int m_sel(int rs, bit used);
    int  best;
    bit  bld;
    best = 1000;
    bld  = 1'b0;
    if (!used || rs == 0) return 0;
    foreach (hist[i]) begin
      int d;
      d = cyc - hist[i].t;
      if (hist[i].we && hist[i].rd == rs && d >= 1 && d <= N && d < best) begin
        best = d;
        bld  = hist[i].ld;
      end
    end
    if (best == 1) return bld ? 0 : 1;
    if (best == 2) return 2;
    if (best == N && STAGES > 4) return 3;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input id_t id, input bit br);
    bit hz, fl, adv;
    reset       = rst;
    id_valid    = id.v;
    id_rs1      = 5'(id.rs1);
    id_rs2      = 5'(id.rs2);
    id_use1     = id.u1;
    id_use2     = id.u2;
    id_rd       = 5'(id.rd);
    id_regwen   = id.we;
    id_load     = id.ld;
    ex_br_taken = br;
    #2;
    hz = !rst && id.v && (m_hz(id.rs1, id.u1) || m_hz(id.rs2, id.u2));
    fl = !rst && br;
    chk("stall_if", 32'(stall_if), 32'(hz && !fl));
    chk("stall_id", 32'(stall_id), 32'(hz && !fl));
    chk("bubble_ex", 32'(bubble_ex), 32'(hz || fl));
    chk("flush_ifid", 32'(flush_ifid), 32'(fl));
    obs_stall = stall_if;
    adv = !rst && id.v && !hz && !br;
    last_adv = adv;
    if (rst) begin
      hist.delete();
      m_cnt = 0; m_cnt_s = 0; m_fa = 0; m_fb = 0;
    end else begin
      if (hz && !fl) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      m_fa = (Fwd && adv) ? m_sel(id.rs1, id.u1) : 0;
      m_fb = (Fwd && adv) ? m_sel(id.rs2, id.u2) : 0;
      if (adv) hist.push_back('{cyc, id.rd, id.we, id.ld});
    end
    cyc++;
    while (hist.size() > 0 && cyc - hist[0].t > N) void'(hist.pop_front());
    @(posedge clk);
    #1;
    chk("inflight", 32'(inflight), 32'(hist.size()));
    chk("inflight_s", 32'(inflight_s), 32'(hist.size()));
    chk("fwd_a", 32'(fwd_a), 32'(m_fa));
    chk("fwd_b", 32'(fwd_b), 32'(m_fb));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    chk("stall_cnt_s", 32'(stall_cnt_s), 32'(m_cnt_s));
  endtask

  // Present one instruction until it leaves ID (bounded), then check its stall count.
  task automatic issue(input string tag, input id_t id, input int exp_stalls);
    int stalls, n;
    stalls = 0;
    n = 0;
    do begin
      step(1'b0, id, 1'b0);
      if (obs_stall) stalls++;
      n++;
    end while (!last_adv && n < 12);
    chk(tag, 32'(stalls), 32'(exp_stalls));
  endtask

  task automatic drain();
    for (int i = 0; i < N + 1; i++) step(1'b0, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
  endtask

  initial begin
    id_t idle, dep;
    int  cnt_before;
    tests = 0; fails = 0; cyc = 0;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

    step(1'b1, idle, 1'b0);
    step(1'b1, idle, 1'b0);

    // ALU producer then dependent consumer.
    issue("add_x5", mk(1, 1, 2, 1, 1, 5, 1, 0), 0);
    issue("alu_use_stalls", mk(1, 5, 1, 1, 1, 6, 1, 0), Fwd ? 0 : 3);
    chk("alu_use_fwd_a", 32'(fwd_a), Fwd ? 32'd1 : 32'd0);
    chk("alu_use_cnt", 32'(stall_cnt), Fwd ? 32'd0 : 32'd3);
    drain();

    // Load producer then dependent consumer.
    issue("lw_x5", mk(1, 2, 0, 1, 0, 5, 1, 1), 0);
    issue("load_use_stalls", mk(1, 5, 0, 1, 1, 6, 1, 0), Fwd ? 1 : 3);
    chk("load_use_fwd_a", 32'(fwd_a), Fwd ? 32'd2 : 32'd0);
    drain();

    // x0 never creates a dependency.
    issue("wr_x0", mk(1, 1, 1, 1, 1, 0, 1, 0), 0);
    issue("rd_x0_stalls", mk(1, 0, 0, 1, 1, 7, 1, 0), 0);
    chk("rd_x0_fwd_a", 32'(fwd_a), 32'd0);
    drain();

    // Load-use coinciding with a taken branch: flush wins, no count, bubble inserted.
    issue("lw_x5_br", mk(1, 2, 0, 1, 0, 5, 1, 1), 0);
    cnt_before = m_cnt;
    dep = mk(1, 5, 0, 1, 1, 6, 1, 0);
    step(1'b0, dep, 1'b1);
    chk("br_cnt_unchanged", 32'(stall_cnt), 32'(cnt_before));
    chk("br_inflight", 32'(inflight), 32'd1);
    drain();

    // Reset in the second stall cycle, then the dependent instruction goes straight through.
    issue("add_x5_rst", mk(1, 1, 2, 1, 1, 5, 1, 0), 0);
    step(1'b0, dep, 1'b0);
    step(1'b1, dep, 1'b0);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    step(1'b0, dep, 1'b0);
    chk("post_rst_nostall", 32'(obs_stall), 32'd0);
    drain();

    // Enough load-use pairs to drive the narrow counter into saturation.
    for (int i = 0; i < 20; i++) begin
      issue("sat_prod", mk(1, 2, 0, 1, 0, 5, 1, 1), 0);
      issue("sat_cons", mk(1, 5, 5, 1, 1, 6, 1, 0), Fwd ? 1 : 3);
      drain();
    end
    chk("cnt_sat_s", 32'(stall_cnt_s), 32'd15);
    chk("cnt_wide", 32'(stall_cnt), 32'(m_cnt));

    // Random traffic over a small register set to provoke frequent overlaps.
    for (int k = 0; k < 400; k++) begin
      id_t r;
      r.v   = ($urandom_range(0, 9) < 8);
      r.rs1 = $urandom_range(0, 3);
      r.rs2 = $urandom_range(0, 3);
      r.u1  = ($urandom_range(0, 3) != 0);
      r.u2  = ($urandom_range(0, 1) != 0);
      r.rd  = $urandom_range(0, 3);
      r.we  = ($urandom_range(0, 3) != 0);
      r.ld  = ($urandom_range(0, 2) == 0);
      step(($urandom_range(0, 49) == 0), r, ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
